ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch front end of the DLX pipeline; the requesting side of the synchronous instruction ROM.
- Generates word addresses into the ROM, which has a registered read: address sampled at a clock edge, data valid the following cycle.
- Tracks the in-flight read and buffers returned instructions in a small FIFO.
- Presents instructions to decode over a valid/ready handshake and handles PC redirects from branch/jump resolution.

Parameters:
- DATA_WIDTH, 32, instruction width; matches the ROM data width.
- ADDR_WIDTH, 10, ROM word-address width.
- PC_WIDTH, 32, byte-address program counter width.
- RESET_PC, 0, byte address fetched first after reset.
- FIFO_DEPTH, 2, output buffer entries; minimum 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rom_addr  out  ADDR_WIDTH  word address to the ROM; equals pc[ADDR_WIDTH+1:2].
- rom_rdata  in  DATA_WIDTH  ROM read data for the address sampled at the previous edge.
- rom_rdata_valid  in  1  ROM data-valid qualifier.
- redirect_valid  in  1  one-cycle pulse to redirect fetch.
- redirect_pc  in  PC_WIDTH  new byte PC; bits [1:0] are ignored.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  DATA_WIDTH  instruction word.
- out_pc  out  PC_WIDTH  byte PC of out_instr; bits [1:0] are always 0.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC, inflight = 0, FIFO empty.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - rom_addr = RESET_PC word address.
- Issue:
  - A request is issued in cycle t when count + inflight − pop < FIFO_DEPTH, where pop = out_valid & out_ready.
  - rom_addr (combinational from fetch_pc) is sampled by the ROM at the end of t; fetch_pc += 4 and inflight = 1 with the request PC recorded.
  - If the issue condition fails, rom_addr holds the same fetch_pc and nothing is recorded.
- Return:
  - In cycle t+1, if inflight and rom_rdata_valid, push {pc, rom_rdata} into the FIFO.
  - If rom_rdata_valid = 0, the request stays in flight, rom_addr re-presents its PC, and no new request is issued.
- Latency and throughput:
  - Issue at t gives out_valid at t+2 when the FIFO is empty.
  - Sustained throughput is 1 instruction/cycle while out_ready stays high.
- Output:
  - FIFO head drives out_valid/out_instr/out_pc.
  - These hold stable while out_valid & !out_ready.
  - Push and pop in the same cycle are allowed, including at full.
- Redirect in cycle t:
  - rom_addr = redirect_pc word address, combinationally in the same cycle; that request is issued unconditionally.
  - fetch_pc = redirect_pc + 4 (low bits cleared); any inflight response returning in t is discarded.
  - The FIFO is cleared at the end of t; out_valid = 0 in t+1.
  - The redirect target reaches out_valid in t+2.
  - A valid&ready transfer in cycle t still completes; squashing it is decode's responsibility.
- Wrap-around: fetch_pc wraps modulo 2^PC_WIDTH; rom_addr wraps modulo 2^ADDR_WIDTH, with no special handling.
- Reset mid-operation: all state returns to reset values immediately; pending data is lost.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched (32, count of completed out_valid&out_ready transfers) and perf_stall (32, count of cycles with out_valid & !out_ready).
  - Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ifetch_pkg:
  - typedef fetch_entry_t {pc, instr};
  - constants WORD_BYTES = 4 and PC_LSB = 2.
- Sub-module ifetch_fifo:
  - parameterised synchronous FIFO of fetch_entry_t with synchronous clear;
  - exposes count, and allows push+pop at full.

Test Plan:
- Reset, out_ready = 1, ROM word n = n → out_valid first at cycle 2 after reset release; out_pc 0, 4, 8, … with out_instr 0, 1, 2, … back-to-back.
- out_ready low for 5 cycles mid-stream → out_instr/out_pc held stable; no word lost or duplicated; issue stops at FIFO_DEPTH; stream resumes in order.
- redirect_valid with redirect_pc = 0x100 while FIFO is full → out_valid = 0 next cycle; next output pc = 0x100, instr = word 64.
- redirect_pc = 0x103 → out_pc = 0x100; rom_addr = 64 in the redirect cycle.
- rom_rdata_valid forced low for 3 cycles → rom_addr held at the in-flight PC; no push; order preserved afterwards.
- Stream to pc = 0xFFC with ADDR_WIDTH = 10 → next rom_addr = 0, out_pc = 0x1000; reset_n asserted mid-stream → out_valid = 0 immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared fetch-entry type and byte/word addressing constants
package ifetch_pkg;
    localparam int WORD_BYTES   = 4;
    localparam int PC_LSB       = 2;
    localparam int ENTRY_PC_W   = 32;
    localparam int ENTRY_DATA_W = 32;
    typedef struct packed {
        logic [ENTRY_PC_W-1:0]   pc;
        logic [ENTRY_DATA_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch entries with sync clear; push+pop allowed at full
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CW-1:0]   count_q;
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    // storage, circular pointers and occupancy; clear drops every entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= (wr_q == LAST) ? '0 : wr_q + PW'(1);
            end
            if (pop_i) rd_q <= (rd_q == LAST) ? '0 : rd_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: DLX instruction-fetch front end; optional perf counters via IFETCH_PERF_EN
module ifetch
    import ifetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic                  rom_rdata_valid,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]   out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(WORD_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] START_PC   = RESET_PC & ALIGN_MASK;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] issue_pc;
    logic [CW-1:0]       count;
    logic [SW-1:0]       occ, lim;
    logic                stall, pop, push, issue;
    fetch_entry_t        push_entry, head;

    // an outstanding request without valid data blocks new issue and is re-presented
    assign stall     = inflight_q & ~rom_rdata_valid;
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & rom_rdata_valid & ~redirect_valid;
    assign occ       = SW'(count) + SW'(inflight_q);
    assign lim       = SW'(FIFO_DEPTH) + SW'(pop);
    assign issue     = redirect_valid | (~stall & (occ < lim));
    assign issue_pc  = redirect_valid ? (redirect_pc & ALIGN_MASK) : stall ? req_pc_q : fetch_pc_q;
    assign rom_addr  = issue_pc[ADDR_WIDTH+PC_LSB-1:PC_LSB];
    assign out_valid = (count != '0);
    assign out_instr = DATA_WIDTH'(head.instr);
    assign out_pc    = PC_WIDTH'(head.pc);

    // next fetch pointer and in-flight bookkeeping
    always_comb begin
        fetch_pc_d       = issue ? issue_pc + PC_WIDTH'(WORD_BYTES) : fetch_pc_q;
        req_pc_d         = issue ? issue_pc : req_pc_q;
        inflight_d       = issue | stall;
        push_entry.pc    = ENTRY_PC_W'(req_pc_q);
        push_entry.instr = ENTRY_DATA_W'(rom_rdata);
    end

    // fetch state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= START_PC;
            req_pc_q   <= START_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    ifetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i (push_entry),
        .head_o  (head),
        .count_o (count)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    // saturating transfer and decode-stall counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= (pop && !(&perf_fetched_q)) ? perf_fetched_q + 32'd1 : perf_fetched_q;
            perf_stall_q   <= (out_valid && !out_ready && !(&perf_stall_q)) ? perf_stall_q + 32'd1 : perf_stall_q;
        end
    end
    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch with a registered-read ROM model
module tb_ifetch;
    logic        clk;
    logic        reset_n;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic        rom_rdata_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;

    ifetch dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rom_addr        (rom_addr),
        .rom_rdata       (rom_rdata),
        .rom_rdata_valid (rom_rdata_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word n holds value n, registered read
    always @(posedge clk) rom_rdata <= {22'd0, rom_addr};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_pc !== 32'd0 || rom_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b instr=%h pc=%h addr=%0d, want 0 0 0 0", out_valid, out_instr, out_pc, rom_addr);
        end
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_latency c%0d: valid=%b, want 0", c, out_valid);
            end
            next_cycle();
        end
        exp_pc = 32'd0;
    endtask

    task automatic test_back_to_back(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ((exp_pc >> 2) & 32'h3ff)) begin
                n_fail++;
                $display("FAIL back_to_back: valid=%b pc=%h instr=%h, want 1 pc=%h instr=%h",
                         out_valid, out_pc, out_instr, exp_pc, (exp_pc >> 2) & 32'h3ff);
            end
            exp_pc = exp_pc + 32'd4;
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ((exp_pc >> 2) & 32'h3ff)
                || rom_addr !== 10'((exp_pc + 32'd8) >> 2)) begin
                n_fail++;
                $display("FAIL backpressure k=%0d: valid=%b pc=%h instr=%h addr=%0d, want pc=%h addr=%0d",
                         k, out_valid, out_pc, out_instr, rom_addr, exp_pc, 10'((exp_pc + 32'd8) >> 2));
            end
            next_cycle();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        n_checks++;
        if (rom_addr !== 10'd64 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_full_issue: addr=%0d valid=%b, want 64 1", rom_addr, out_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_full_flush: valid=%b, want 0", out_valid);
        end
        next_cycle();
        exp_pc = 32'h100;
    endtask

    task automatic test_redirect_unaligned();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        n_checks++;
        if (rom_addr !== 10'd64) begin
            n_fail++;
            $display("FAIL redirect_unaligned_addr: addr=%0d, want 64", rom_addr);
        end
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_unaligned_flush: valid=%b, want 0", out_valid);
        end
        next_cycle();
        exp_pc = 32'h100;
    endtask

    task automatic test_rom_stall();
        rom_rdata_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc || rom_addr !== 10'((exp_pc + 32'd4) >> 2)) begin
            n_fail++;
            $display("FAIL rom_stall_enter: valid=%b pc=%h addr=%0d, want pc=%h addr=%0d",
                     out_valid, out_pc, rom_addr, exp_pc, 10'((exp_pc + 32'd4) >> 2));
        end
        exp_pc = exp_pc + 32'd4;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || rom_addr !== 10'(exp_pc >> 2)) begin
                n_fail++;
                $display("FAIL rom_stall_hold k=%0d: valid=%b addr=%0d, want 0 addr=%0d", k, out_valid, rom_addr, 10'(exp_pc >> 2));
            end
            next_cycle();
        end
        rom_rdata_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || rom_addr !== 10'((exp_pc + 32'd4) >> 2)) begin
            n_fail++;
            $display("FAIL rom_stall_release: valid=%b addr=%0d, want 0 addr=%0d", out_valid, rom_addr, 10'((exp_pc + 32'd4) >> 2));
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFF0;
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        exp_pc = 32'hFF0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== ((exp_pc >> 2) & 32'h3ff)
                || rom_addr !== 10'((exp_pc + 32'd8) >> 2)) begin
                n_fail++;
                $display("FAIL wrap k=%0d: valid=%b pc=%h instr=%h addr=%0d, want pc=%h instr=%h addr=%0d",
                         k, out_valid, out_pc, out_instr, rom_addr, exp_pc, (exp_pc >> 2) & 32'h3ff, 10'((exp_pc + 32'd8) >> 2));
            end
            exp_pc = exp_pc + 32'd4;
            next_cycle();
        end
    endtask

    task automatic test_mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || rom_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b pc=%h addr=%0d, want 0 0 0", out_valid, out_pc, rom_addr);
        end
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_restart c%0d: valid=%b, want 0", c, out_valid);
            end
            next_cycle();
        end
        exp_pc = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        rom_rdata_valid = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        out_ready = 1'b1;
        exp_pc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back(8);
        test_backpressure();
        test_back_to_back(6);
        test_redirect_full();
        test_back_to_back(4);
        test_redirect_unaligned();
        test_back_to_back(4);
        test_rom_stall();
        test_back_to_back(4);
        test_wrap();
        test_mid_reset();
        test_back_to_back(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
